// File: rtl/uart_defs.sv
// ============================================================================
// Module      : uart_defs (package)
// Description : Shared definitions for the memory-mapped UART transmitter:
//               FSM state encoding, default bus addresses and status-word
//               bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_defs;

  // Transmit FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Default bus addresses
  localparam logic [31:0] c_def_tx_data_addr = 32'h0000_03f0;
  localparam logic [31:0] c_def_tx_stat_addr = 32'h0000_03f4;

  // Status word bit positions
  localparam int c_stat_full    = 0;
  localparam int c_stat_empty   = 1;
  localparam int c_stat_busy    = 2;
  localparam int c_stat_ovf     = 3;
  localparam int c_stat_cnt_lsb = 4;
  localparam int c_stat_cnt_msb = 7;

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous byte FIFO feeding the UART transmitter. A push
//               while full is still accepted when a pop happens in the same
//               cycle. DEPTH must be a power of two and at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [7:0]              din,
  output logic [7:0]              dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int              AW           = $clog2(DEPTH);
  localparam logic [AW:0]     c_full_count = (AW + 1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // Pop only real data; a full FIFO can still take a byte if one leaves now
  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != c_full_count) || w_do_pop);

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == c_full_count);
  assign empty = (r_count == '0);
  assign count = r_count;

  // Storage array: payload only, no reset needed
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally modulo DEPTH
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_mmio.sv
// ============================================================================
// Module      : uart_tx_mmio
// Description : Memory-mapped 8N1 UART transmitter. CPU stores to the data
//               address queue bytes; a baud-timed FSM drains the queue onto
//               tx_out. A status word at the second address supports polling
//               and clearing the sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_mmio
  import uart_defs::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] TX_DATA_ADDR = c_def_tx_data_addr,
  parameter logic [31:0] TX_STAT_ADDR = c_def_tx_stat_addr
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] rw_addr,
  input  logic [31:0] w_data,
  input  logic        w_en,
  output logic [31:0] r_data,
  output logic        hit,
  output logic        tx_out
);

  localparam int            BW          = $clog2(CLKS_PER_BIT);
  localparam int            CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] c_baud_last = BW'(CLKS_PER_BIT - 1);

  // Address decode
  logic w_data_hit;
  logic w_stat_hit;
  logic w_push_req;
  logic w_ovf_set;
  logic w_ovf_clr;

  // FIFO interface
  logic          w_pop;
  logic [7:0]    w_fifo_dout;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;

  // Transmit datapath and FSM
  tx_state_t     r_state;
  tx_state_t     w_state_n;
  logic [BW-1:0] r_baud;
  logic [BW-1:0] w_baud_n;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_n;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_n;
  logic          r_tx;
  logic          w_tx_n;
  logic          w_baud_end;
  logic          r_ovf;
  logic [31:0]   w_status;

  // Only the low byte of store data carries meaning
  logic w_unused_wdata;
  assign w_unused_wdata = &{1'b0, w_data[31:8]};

  assign w_data_hit = (rw_addr == TX_DATA_ADDR);
  assign w_stat_hit = (rw_addr == TX_STAT_ADDR);
  assign w_push_req = w_en && w_data_hit;
  // A byte is dropped only when full and nothing leaves this cycle
  assign w_ovf_set  = w_push_req && w_fifo_full && !w_pop;
  assign w_ovf_clr  = w_en && w_stat_hit && w_data[c_stat_ovf];

  assign hit    = w_data_hit || w_stat_hit;
  assign r_data = w_stat_hit ? w_status : 32'h0;
  assign tx_out = r_tx;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (w_push_req),
    .pop     (w_pop),
    .din     (w_data[7:0]),
    .dout    (w_fifo_dout),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .count   (w_fifo_count)
  );

  // Assemble the status word from registered state
  always_comb begin
    w_status                                = 32'h0;
    w_status[c_stat_full]                   = w_fifo_full;
    w_status[c_stat_empty]                  = w_fifo_empty;
    w_status[c_stat_busy]                   = (r_state != ST_IDLE);
    w_status[c_stat_ovf]                    = r_ovf;
    w_status[c_stat_cnt_msb:c_stat_cnt_lsb] = 4'(w_fifo_count);
  end

  // Sticky overflow flag; a set in the same cycle as a clear wins
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign w_baud_end = (r_baud == c_baud_last);

  // FSM next state, datapath updates and next serial level
  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_pop     = 1'b0;
    w_tx_n    = 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop     = 1'b1;
          w_shift_n = w_fifo_dout;
          w_baud_n  = '0;
          w_bit_n   = '0;
          w_state_n = ST_START;
        end
      end
      ST_START: begin
        if (w_baud_end) begin
          w_baud_n  = '0;
          w_state_n = ST_DATA;
        end else begin
          w_baud_n  = r_baud + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_baud_end) begin
          w_baud_n  = '0;
          w_shift_n = r_shift >> 1;
          if (r_bit == 3'd7) begin
            w_state_n = ST_STOP;
          end else begin
            w_bit_n   = r_bit + 1'b1;
          end
        end else begin
          w_baud_n  = r_baud + 1'b1;
        end
      end
      ST_STOP: begin
        if (w_baud_end) begin
          w_baud_n  = '0;
          w_state_n = ST_IDLE;
        end else begin
          w_baud_n  = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase

    // The serial pin is registered, so derive its level from the next state
    case (w_state_n)
      ST_START: w_tx_n = 1'b0;
      ST_DATA:  w_tx_n = w_shift_n[0];
      default:  w_tx_n = 1'b1;
    endcase
  end

  // FSM state and datapath registers; reset drives the line idle-high at once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
// ============================================================================
// Module      : tb_uart_tx_mmio
// Description : Self-checking bench for uart_tx_mmio with CLKS_PER_BIT=4.
//               Table of bus decode vectors plus directed multi-cycle
//               sequences; a serial monitor decodes frames independently.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_mmio;

  localparam int          CPB  = 4;
  localparam logic [31:0] DADR = 32'h0000_03f0;
  localparam logic [31:0] SADR = 32'h0000_03f4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] rw_addr;
  logic [31:0] w_data;
  logic        w_en;
  logic [31:0] r_data;
  logic        hit;
  logic        tx_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Serial monitor state
  logic [7:0] rx_q[$];
  int         st_q[$];
  int         fr_err = 0;
  logic [7:0] mon_val;
  bit         mon_abort;
  bit         mon_bad;
  int         mon_stamp;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic        exp_hit;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[8];

  logic [7:0] exp_rx[7];
  logic       exp_bit;
  bit         found;
  bit         stuck;

  uart_tx_mmio #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .TX_DATA_ADDR (DADR),
    .TX_STAT_ADDR (SADR)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .rw_addr (rw_addr),
    .w_data  (w_data),
    .w_en    (w_en),
    .r_data  (r_data),
    .hit     (hit),
    .tx_out  (tx_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] d);
    rw_addr = a;
    w_en    = we;
    w_data  = d;
  endtask

  // Decode 8N1 frames off tx_out, sampling every cycle of every bit
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1 && tx_out === 1'b0) begin
        mon_stamp = cyc;
        mon_abort = 1'b0;
        mon_bad   = 1'b0;
        mon_val   = 8'h00;
        for (int k = 1; k < 10 * CPB; k++) begin
          @(negedge clock);
          if (reset_n !== 1'b1) begin
            mon_abort = 1'b1;
          end else if (!mon_abort) begin
            if (k / CPB == 0) begin
              if (tx_out !== 1'b0) mon_bad = 1'b1;
            end else if (k / CPB <= 8) begin
              if (k % CPB == 0) mon_val[k / CPB - 1] = tx_out;
              else if (tx_out !== mon_val[k / CPB - 1]) mon_bad = 1'b1;
            end else begin
              if (tx_out !== 1'b1) mon_bad = 1'b1;
            end
          end
        end
        if (!mon_abort) begin
          if (mon_bad) fr_err++;
          rx_q.push_back(mon_val);
          st_q.push_back(mon_stamp);
        end
      end
    end
  end

  initial begin
    // addr, wen, wdata, exp_hit, exp_rdata (all from the post-reset state)
    tbl[0] = '{SADR,          1'b0, 32'h0,         1'b1, 32'h0000_0002};
    tbl[1] = '{32'h0000_03f8, 1'b0, 32'h0,         1'b0, 32'h0};
    tbl[2] = '{DADR,          1'b0, 32'h0,         1'b1, 32'h0};
    tbl[3] = '{32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    tbl[4] = '{SADR,          1'b1, 32'h0000_0008, 1'b1, 32'h0000_0002};
    tbl[5] = '{SADR,          1'b1, 32'hFFFF_FFF7, 1'b1, 32'h0000_0002};
    tbl[6] = '{32'h0000_03f8, 1'b1, 32'h0000_0041, 1'b0, 32'h0};
    tbl[7] = '{SADR,          1'b0, 32'h0,         1'b1, 32'h0000_0002};

    exp_rx = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hA5};

    // Reset
    reset_n = 1'b0;
    drive(32'h0, 1'b0, 32'h0);
    repeat (3) @(negedge clock);
    #1;
    chk("tx_in_reset", {31'h0, tx_out}, 32'h1);
    reset_n = 1'b1;

    // Decode / status table
    foreach (tbl[i]) begin
      @(negedge clock);
      drive(tbl[i].addr, tbl[i].wen, tbl[i].wdata);
      #1;
      chk($sformatf("tbl%0d_hit", i), {31'h0, hit}, {31'h0, tbl[i].exp_hit});
      chk($sformatf("tbl%0d_rdata", i), r_data, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_tx", i), {31'h0, tx_out}, 32'h1);
    end

    // Single byte 0x55: latency, waveform, busy window
    @(negedge clock);
    drive(DADR, 1'b1, 32'h0000_0055);
    @(negedge clock);
    drive(SADR, 1'b0, 32'h0);
    #1;
    chk("s2_tx_after_push", {31'h0, tx_out}, 32'h1);
    chk("s2_stat_after_push", r_data, 32'h0000_0010);
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clock);
      #1;
      if (i / CPB == 0)      exp_bit = 1'b0;
      else if (i / CPB <= 8) exp_bit = (8'h55 >> (i / CPB - 1)) & 1'b1;
      else                   exp_bit = 1'b1;
      chk($sformatf("s2_tx_c%0d", i), {31'h0, tx_out}, {31'h0, exp_bit});
      if (i == 0)  chk("s2_stat_busy_first", r_data, 32'h0000_0006);
      if (i == 39) chk("s2_stat_busy_last", r_data, 32'h0000_0006);
    end
    @(negedge clock);
    #1;
    chk("s2_tx_idle", {31'h0, tx_out}, 32'h1);
    chk("s2_stat_idle", r_data, 32'h0000_0002);

    // Six pushes: one popped at once, four queued, one dropped
    for (int b = 1; b <= 6; b++) begin
      @(negedge clock);
      drive(DADR, 1'b1, 32'(b));
    end
    @(negedge clock);
    drive(SADR, 1'b0, 32'h0);
    #1;
    chk("s3_stat_full_ovf", r_data, 32'h0000_004D);

    // Overflow clear, then a no-op status store
    drive(SADR, 1'b1, 32'h0000_0008);
    @(negedge clock);
    drive(SADR, 1'b0, 32'h0);
    #1;
    chk("s4_stat_ovf_cleared", r_data, 32'h0000_0045);
    drive(SADR, 1'b1, 32'h0000_0000);
    @(negedge clock);
    drive(SADR, 1'b0, 32'h0);
    #1;
    chk("s4_stat_noop_store", r_data, 32'h0000_0045);

    // Push 0xA5 exactly in the IDLE cycle that pops from a full FIFO
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clock);
      #1;
      if (r_data[2] == 1'b0) found = 1'b1;
    end
    chk("s5_idle_seen", {31'h0, found}, 32'h1);
    drive(DADR, 1'b1, 32'h0000_00A5);
    @(negedge clock);
    drive(SADR, 1'b0, 32'h0);
    #1;
    chk("s5_stat_push_pop", r_data, 32'h0000_0045);

    // Drain everything
    found = 1'b0;
    for (int t = 0; t < 800 && !found; t++) begin
      @(negedge clock);
      #1;
      if (r_data == 32'h0000_0002) found = 1'b1;
    end
    chk("s5_drained", {31'h0, found}, 32'h1);

    // Reset during DATA bit 3 of 0x00 with 0x7E queued behind it
    @(negedge clock);
    drive(DADR, 1'b1, 32'h0000_0000);
    @(negedge clock);
    drive(DADR, 1'b1, 32'h0000_007E);
    @(negedge clock);
    drive(SADR, 1'b0, 32'h0);
    #1;
    chk("s6_stat_frame", r_data, 32'h0000_0014);
    repeat (17) @(negedge clock);
    #1;
    chk("s6_bit3_low", {31'h0, tx_out}, 32'h0);
    reset_n = 1'b0;
    #1;
    chk("s6_async_tx_high", {31'h0, tx_out}, 32'h1);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    stuck = 1'b0;
    repeat (80) begin
      @(negedge clock);
      if (tx_out !== 1'b1) stuck = 1'b1;
    end
    #1;
    chk("s6_no_frames_after_reset", {31'h0, stuck}, 32'h0);
    chk("s6_stat_after_reset", r_data, 32'h0000_0002);

    // Received stream, frame shape and inter-frame gaps
    chk("rx_count", 32'(rx_q.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("rx_byte%0d", i),
          (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD_BEEF, {24'h0, exp_rx[i]});
    end
    for (int i = 1; i < 6; i++) begin
      chk($sformatf("gap%0d", i),
          (i + 1 < st_q.size()) ? 32'(st_q[i + 1] - st_q[i]) : 32'hDEAD_BEEF,
          32'(10 * CPB + 1));
    end
    chk("frame_errors", 32'(fr_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
